palette_regfile: RTL
====================

// Module: palette_regfile
// PURPOSE
//  DataBus responder owning the three DMG palette registers: BGP @FF47, OBP0 @FF48, OBP1 @FF49.
//  Decodes CPU writes into per-palette indexedColors[0:3] (2-bit shades) and answers CPU reads.
//  Serves the renderer's pixel-lookup stream: (palette, colour index) in -> shade out, 2-cycle pipeline.
//  Sits inside whizgraphics between the bus and the line renderer; replaces ad-hoc palette decode.
// PARAMETERS
//  ADDR_SIZE      16        bus address width
//  DATA_SIZE      8         bus data width
//  BGP_ADDR       16'hFF47  background palette address
//  OBP0_ADDR      16'hFF48  sprite palette 0 address
//  OBP1_ADDR      16'hFF49  sprite palette 1 address
//  RESET_PALETTE  8'hE4     reset value of all three registers (identity: index j -> shade j)
//  DEBUG_OUT      0         1: expose indexedPalettes[PaletteType][0:3] on dbg_palettes
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-high reset
//  bus_addr      in   ADDR_SIZE  CPU address
//  bus_wdata     in   DATA_SIZE  CPU write data
//  bus_we        in   1          write strobe, one cycle
//  bus_re        in   1          read strobe, one cycle
//  bus_rdata     out  DATA_SIZE  read data, valid when bus_rvalid
//  bus_rvalid    out  1          read response for a decoded address
//  lk_valid      in   1          lookup request valid
//  lk_ready      out  1          lookup request accepted this cycle when lk_valid & lk_ready
//  lk_palette    in   2          PaletteType: 0 BGP, 1 OBP0, 2 OBP1 (3 illegal)
//  lk_index      in   2          raw colour index from tile data
//  px_valid      out  1          output pixel valid
//  px_ready      in   1          downstream accepts pixel
//  px_shade      out  2          resolved Color
//  px_transparent out 1          1 when palette is OBP0/OBP1 and lk_index == 0
//  dbg_palettes  out  3x4x2      decoded palettes (tied 0 when DEBUG_OUT == 0)
// BEHAVIOUR
//  Reset: all regs = RESET_PALETTE; bus_rdata 0, bus_rvalid 0; pipeline valids 0; px_* 0. Applies mid-stream.
//  Decode: indexedColors[j] = reg[2j+1:2j]. Write on bus_we & address hit, visible to lookups next edge.
//  Read: bus_re & hit -> next cycle bus_rvalid=1, bus_rdata=reg; OBP reads return bits[1:0] as written.
//    Miss -> bus_rvalid 0, bus_rdata 0. Simultaneous we+re same address: read returns old value.
//  Lookup pipeline: S1 accepts request, resolves shade from CURRENT register (pre-write if same edge);
//    S2 holds result to px_*. Latency: accepted at edge N -> px_valid after edge N+2 when unstalled.
//  Backpressure: S2 holds while px_valid & !px_ready; S1 advances only if S2 empty or draining;
//    lk_ready = !S1_valid | S1_advances. Full throughput 1 pixel/cycle when px_ready held 1.
//  In-flight pixels carry already-resolved shades; later palette writes never alter them.
//  lk_palette == 3: px_shade 0, px_transparent 1 (no error flag).
//  Order preserved; no drops, no duplicates across stalls.
// STRUCTURE
//  video_types package: PaletteType enum {BGP,OBP0,OBP1}, Color (2-bit), Palette struct
//    {Color indexedColors[4]}, address localparams PAL_BGP/OBP0/OBP1_ADDR, PAL_RESET_VALUE.
//  Sub-module palette_lookup_pipe: 2-stage valid/ready pipeline, receives decoded palette array.
//  Top holds registers, bus decode and read-response flops.
// TESTING
//  Reset, no bus traffic -> every palette p, index j: dbg_palettes[p][j] == j; reads all return 8'hE4.
//  Write BGP 8'h1B; lookup BGP idx 0..3 back-to-back, px_ready=1 -> shades 3,2,1,0 on 4 consecutive cycles.
//  Lookup OBP1 idx 0 -> px_transparent 1; idx 2 after OBP1=8'h30 -> shade 3, transparent 0.
//  Write BGP 8'h00 on same edge a BGP idx 3 lookup accepted (reset value) -> that pixel shade 3; next lookup 0.
//  Hold px_ready=0 for 5 cycles with 4 requests offered -> 2 accepted, lk_ready 0, px_* stable; release -> in order.
//  Assert reset with both stages full -> px_valid 0 immediately, regs read back 8'hE4 after release.

Source files
------------

// File: rtl/video_types.sv
// Shared video types: palette selectors, 2-bit shades, decoded palettes and bus addresses.
package video_types;

  typedef enum logic [1:0] {
    BGP  = 2'd0,
    OBP0 = 2'd1,
    OBP1 = 2'd2
  } PaletteType;

  typedef logic [1:0] Color;

  // indexedColors[j] occupies raw bits [2j+1:2j]
  typedef struct packed {
    Color [3:0] indexedColors;
  } Palette;

  localparam logic [15:0] PAL_BGP_ADDR    = 16'hFF47;
  localparam logic [15:0] PAL_OBP0_ADDR   = 16'hFF48;
  localparam logic [15:0] PAL_OBP1_ADDR   = 16'hFF49;
  localparam logic [7:0]  PAL_RESET_VALUE = 8'hE4;

  function automatic Palette decode_palette(input logic [7:0] raw);
    return Palette'(raw);
  endfunction

endpackage

// File: rtl/palette_lookup_pipe.sv
// Two-stage valid/ready lookup pipe: S1 resolves (palette, index) to a shade, S2 presents it.
module palette_lookup_pipe
  import video_types::*;
(
  input  logic           clk,
  input  logic           reset,
  input  Palette [2:0]   i_palettes,
  input  logic           i_lk_valid,
  output logic           o_lk_ready,
  input  logic [1:0]     i_lk_palette,
  input  logic [1:0]     i_lk_index,
  output logic           o_px_valid,
  input  logic           i_px_ready,
  output Color           o_px_shade,
  output logic           o_px_transparent
);

  logic r_s1_valid;
  Color r_s1_shade;
  logic r_s1_transp;
  logic r_s2_valid;
  Color r_s2_shade;
  logic r_s2_transp;

  logic w_s2_free;
  logic w_s1_adv;
  logic w_accept;
  Color w_shade;
  logic w_transp;

  assign w_s2_free  = !r_s2_valid || i_px_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign o_lk_ready = !r_s1_valid || w_s1_adv;
  assign w_accept   = i_lk_valid && o_lk_ready;

  // Selector 3 is illegal: report transparent black rather than flag an error
  always_comb begin
    w_shade  = '0;
    w_transp = 1'b1;
    case (i_lk_palette)
      2'd0: begin
        w_shade  = i_palettes[0].indexedColors[i_lk_index];
        w_transp = 1'b0;
      end
      2'd1: begin
        w_shade  = i_palettes[1].indexedColors[i_lk_index];
        w_transp = (i_lk_index == 2'd0);
      end
      2'd2: begin
        w_shade  = i_palettes[2].indexedColors[i_lk_index];
        w_transp = (i_lk_index == 2'd0);
      end
      default: begin
        w_shade  = '0;
        w_transp = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_shade  <= '0;
      r_s1_transp <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_shade  <= '0;
      r_s2_transp <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid  <= 1'b1;
        r_s1_shade  <= w_shade;
        r_s1_transp <= w_transp;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_shade  <= r_s1_shade;
          r_s2_transp <= r_s1_transp;
        end
      end
    end
  end

  assign o_px_valid       = r_s2_valid;
  assign o_px_shade       = r_s2_shade;
  assign o_px_transparent = r_s2_transp;

endmodule

// File: rtl/palette_regfile.sv
// DMG palette registers (BGP/OBP0/OBP1): bus write/read decode plus the renderer lookup pipe.
module palette_regfile
  import video_types::*;
#(
  parameter int unsigned            ADDR_SIZE     = 16,
  parameter int unsigned            DATA_SIZE     = 8,
  parameter logic [ADDR_SIZE-1:0]   BGP_ADDR      = ADDR_SIZE'(PAL_BGP_ADDR),
  parameter logic [ADDR_SIZE-1:0]   OBP0_ADDR     = ADDR_SIZE'(PAL_OBP0_ADDR),
  parameter logic [ADDR_SIZE-1:0]   OBP1_ADDR     = ADDR_SIZE'(PAL_OBP1_ADDR),
  parameter logic [7:0]             RESET_PALETTE = PAL_RESET_VALUE,
  parameter bit                     DEBUG_OUT     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_SIZE-1:0]  bus_addr,
  input  logic [DATA_SIZE-1:0]  bus_wdata,
  input  logic                  bus_we,
  input  logic                  bus_re,
  output logic [DATA_SIZE-1:0]  bus_rdata,
  output logic                  bus_rvalid,
  input  logic                  lk_valid,
  output logic                  lk_ready,
  input  logic [1:0]            lk_palette,
  input  logic [1:0]            lk_index,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [1:0]            px_shade,
  output logic                  px_transparent,
  output logic [2:0][3:0][1:0]  dbg_palettes
);

  logic [2:0][7:0]      r_pal;
  logic                 r_rvalid;
  logic [DATA_SIZE-1:0] r_rdata;

  logic [2:0]   w_hit;
  logic [7:0]   w_rd_sel;
  Palette [2:0] w_palettes;

  assign w_hit[0] = (bus_addr == BGP_ADDR);
  assign w_hit[1] = (bus_addr == OBP0_ADDR);
  assign w_hit[2] = (bus_addr == OBP1_ADDR);

  always_comb begin
    w_rd_sel = '0;
    for (int p = 0; p < 3; p++) begin
      if (w_hit[p]) w_rd_sel = r_pal[p];
      w_palettes[p] = decode_palette(r_pal[p]);
    end
  end

  // Read samples the pre-write value, so a same-cycle write+read returns the old contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pal    <= {3{RESET_PALETTE}};
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (bus_we && w_hit[p]) r_pal[p] <= bus_wdata[7:0];
      end
      r_rvalid <= bus_re && (|w_hit);
      r_rdata  <= (bus_re && (|w_hit)) ? DATA_SIZE'(w_rd_sel) : '0;
    end
  end

  assign bus_rvalid = r_rvalid;
  assign bus_rdata  = r_rdata;

  if (DEBUG_OUT) begin : g_dbg
    assign dbg_palettes = w_palettes;
  end else begin : g_no_dbg
    assign dbg_palettes = '0;
  end

  palette_lookup_pipe u_pipe (
    .clk              (clk),
    .reset            (reset),
    .i_palettes       (w_palettes),
    .i_lk_valid       (lk_valid),
    .o_lk_ready       (lk_ready),
    .i_lk_palette     (lk_palette),
    .i_lk_index       (lk_index),
    .o_px_valid       (px_valid),
    .i_px_ready       (px_ready),
    .o_px_shade       (px_shade),
    .o_px_transparent (px_transparent)
  );

endmodule
